game_ctrl: RTL

Sequencing controller for the 8x8 lights-out style puzzle datapath. Owns the board register, debounces the four move buttons and the restart button, and issues one step request per complete press/release gesture carrying the selected label group. Latches the datapath result, counts moves and declares game over. Sits between the raw board inputs and the combinational/registered board-update datapath; its `board` output drives the LED matrix.

---
 rtl/game_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Lights-out puzzle sequencer: debounces five raw buttons, owns the board register,
// issues one step request per move gesture and tracks the move count and game-over state.
module game_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          MAX_MOVES       = 99,
  parameter logic [63:0] INIT_BOARD      = 64'h8142_2418_1824_4281
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            b1,
  input  logic            b2,
  input  logic            b3,
  input  logic            b4,
  input  logic            restart,
  output logic            step_req,
  output logic [2:0]      step_label,
  output logic [7:0][7:0] step_board,
  input  logic            step_ack,
  input  logic [7:0][7:0] next_board,
  output logic [7:0][7:0] board,
  output logic [6:0]      move_count,
  output logic            busy,
  output logic            game_over,
  output logic            out_of_moves
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam int            CW        = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    MAX_COUNT = 7'(MAX_MOVES);

  logic [4:0]      raw_s;
  logic [4:0]      sync1_r;
  logic [4:0]      sync2_r;
  logic [4:0]      deb_r;
  logic [CW-1:0]   cnt_r [5];
  logic            restart_prev_r;
  logic            restart_rise_s;
  logic            any_s;
  logic [2:0]      high_s;
  logic [6:0]      next_count_s;

  logic [1:0]      state_r;
  logic [2:0]      label_r;
  logic [7:0][7:0] board_r;
  logic [6:0]      move_count_r;
  logic            step_req_r;
  logic [2:0]      step_label_r;
  logic            out_of_moves_r;

  // bit 4 is restart, bits 3..0 are b4..b1
  assign raw_s = {restart, b4, b3, b2, b1};

  // two-flop synchronizers plus per-input stability counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r        <= 5'd0;
      sync2_r        <= 5'd0;
      deb_r          <= 5'd0;
      restart_prev_r <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r        <= raw_s;
      sync2_r        <= sync1_r;
      restart_prev_r <= deb_r[4];
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            deb_r[i] <= sync2_r[i];
            cnt_r[i] <= {CW{1'b0}};
          end else begin
            cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_r[i] <= {CW{1'b0}};
        end
      end
    end
  end

  assign restart_rise_s = deb_r[4] & ~restart_prev_r;
  assign any_s          = |deb_r[3:0];

  // highest-numbered pressed button selects the label group
  always_comb begin
    high_s = 3'd0;
    if (deb_r[3]) begin
      high_s = 3'd4;
    end else if (deb_r[2]) begin
      high_s = 3'd3;
    end else if (deb_r[1]) begin
      high_s = 3'd2;
    end else if (deb_r[0]) begin
      high_s = 3'd1;
    end else begin
      high_s = 3'd0;
    end
  end

  // saturating increment of the move counter
  always_comb begin
    next_count_s = MAX_COUNT;
    if (move_count_r >= MAX_COUNT) begin
      next_count_s = MAX_COUNT;
    end else begin
      next_count_s = move_count_r + 7'd1;
    end
  end

  // game sequencing FSM; restart outranks everything including a pending ack
  always_ff @(posedge clk) begin
    if (reset || restart_rise_s) begin
      state_r        <= S_IDLE;
      label_r        <= 3'd0;
      board_r        <= INIT_BOARD;
      move_count_r   <= 7'd0;
      step_req_r     <= 1'b0;
      step_label_r   <= 3'd0;
      out_of_moves_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_s) begin
            state_r <= S_HELD;
            label_r <= high_s;
          end
        end
        S_HELD: begin
          if (any_s) begin
            label_r <= high_s;
          end else begin
            state_r      <= S_REQ;
            step_req_r   <= 1'b1;
            step_label_r <= label_r;
          end
        end
        S_REQ: begin
          if (step_ack) begin
            board_r      <= next_board;
            move_count_r <= next_count_s;
            step_req_r   <= 1'b0;
            step_label_r <= 3'd0;
            label_r      <= 3'd0;
            if (next_board == 64'd0) begin
              state_r        <= S_OVER;
              out_of_moves_r <= 1'b0;
            end else if (next_count_s == MAX_COUNT) begin
              state_r        <= S_OVER;
              out_of_moves_r <= 1'b1;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          state_r <= S_OVER;
        end
        default: begin
          state_r      <= S_IDLE;
          step_req_r   <= 1'b0;
          step_label_r <= 3'd0;
        end
      endcase
    end
  end

  assign step_req     = step_req_r;
  assign step_label   = step_label_r;
  assign board        = board_r;
  assign step_board   = board_r;
  assign move_count   = move_count_r;
  assign out_of_moves = out_of_moves_r;
  assign busy         = (state_r == S_HELD) || (state_r == S_REQ);
  assign game_over    = (state_r == S_OVER);

endmodule
